rca_share_arb: RTL and testbench
================================

// Module: rca_share_arb
// PURPOSE
//  Round-robin arbiter/sequencer sharing one registered ripple-carry adder (rca_w_regs)
//  between two requesters. Each requester presents operands via valid/ready. Winner's
//  operands go to the adder; results return tagged with the requester ID. Fixed latency, no output backpressure.
//  Sits between producers and the shared adder datapath.
// PARAMETERS
//  WIDTH   4  operand width in bits; sum is WIDTH+1 bits
//  BURST   2  max consecutive grants to one requester while the other is waiting (>=1)
// PORTS
//  clk        in   1          clock, rising edge
//  rstn       in   1          asynchronous active-low reset
//  en         in   1          1: grants allowed; 0: no new grants, in-flight ops drain
//  in_valid   in   2          per-requester operand valid (bit i = requester i)
//  in_ready   out  2          per-requester grant; one-hot or zero; combinational
//  a0, b0     in   WIDTH      requester 0 operands
//  a1, b1     in   WIDTH      requester 1 operands
//  out_valid  out  1          result valid, registered
//  out_id     out  1          requester ID of result, registered
//  out_sum    out  WIDTH+1    a+b of accepted op, registered (adder data_out)
//  idle       out  1          1 when no op is in flight in the adder pipeline
// BEHAVIOUR
//  Reset (async, rstn=0): out_valid=0, out_id=0, out_sum=0, idle=1, last_owner=1,
//   burst_cnt=0, adder operand/output regs cleared. In-flight ops are discarded; no result emitted.
//  Acceptance: op from requester i accepted at rising edge where in_valid[i]&in_ready[i].
//   At most one acceptance per cycle.
//  Grant (combinational from en, in_valid, last_owner, burst_cnt):
//   en=0 -> in_ready=00.
//   Only one requester valid -> it is granted.
//   Both valid: if last_owner valid-holder and burst_cnt<BURST -> keep last_owner;
//   else grant the other requester. After reset, requester 0 wins the first tie.
//  last_owner <= granted ID on each acceptance. burst_cnt <= 1 on owner change,
//   burst_cnt+1 (saturating at BURST) on repeat grant. Cycles with no acceptance leave both unchanged.
//  Adder drive: granted requester's a/b muxed to adder inputs; no grant -> zeros.
//  Latency: accepted at edge k -> out_valid=1, out_id, out_sum valid after edge k+1
//   (operand reg at k, output reg at k+1). Back-to-back acceptances give back-to-back
//   results in acceptance order. Throughput 1 op/cycle.
//  Tag pipeline: 2 stages {valid,id} aligned to adder operand and output regs.
//   Bubble cycles produce out_valid=0. out_sum during out_valid=0 is don't-care.
//  Arithmetic: out_sum = zero-extended a + zero-extended b, WIDTH+1 bits, never overflows.
//  idle = ~stage1_valid & ~stage2_valid (registered valids), i.e. 1 once last result has been presented.
//  en deassert mid-burst: no new grants; ops already accepted still complete; burst_cnt held.
//  Requester dropping in_valid while not granted is legal; arbiter keeps no pending state for it.
//  Upstream rule: operands must be stable while in_valid=1 and not accepted.
// STRUCTURE
//  Package rca_arb_pkg: ID width constant (1), requester count constant (2), localparam
//   for pipeline latency (2 stages) used by bench scoreboards.
//  One sub-module: rca_w_regs #(.width(WIDTH)) as the shared adder. Grant logic, burst counter
//   and 2-stage tag pipeline live in this module.
// TESTING (WIDTH=4, BURST=2)
//  1 Reset: rstn=0 mid-traffic -> out_valid=0, idle=1 immediately; after release, no stale results.
//  2 Single: req0 a=3,b=5 accepted at edge k -> after edge k+1 out_valid=1,id=0,sum=8; then out_valid=0.
//  3 Overflow: req1 a=15,b=15 -> sum=5'd30, id=1; a=15,b=1 -> sum=16.
//  4 Contention: both valid every cycle -> grant order 0,0,1,1,0,0...;
//    results in the same order, one per cycle.
//  5 Burst release: req0 only for 5 cycles -> 5 consecutive grants to 0; req1 rises ->
//    granted within BURST cycles.
//  6 en=0 with 2 ops in flight -> in_ready=00, both results emitted, then idle=1;
//    en=1 -> arbitration resumes.

Source files
------------

// File: rtl/rca_arb_pkg.sv
// rca_arb_pkg: shared constants and tag type for the two-requester adder arbiter
package rca_arb_pkg;
  localparam int ID_W = 1;
  localparam int N_REQ = 2;
  localparam int PIPE_LAT = 2;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/rca_w_regs.sv
// rca_w_regs: ripple-carry adder with registered operands and registered sum
module rca_w_regs #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width:0]   data_out
);
  logic [width-1:0] a_r, b_r;
  logic [width:0] c, sum;
  always_comb begin
    c = '0;
    sum = '0;
    for (int i = 0; i < width; i++) begin
      sum[i] = a_r[i] ^ b_r[i] ^ c[i];
      c[i+1] = (a_r[i] & b_r[i]) | (c[i] & (a_r[i] ^ b_r[i]));
    end
    sum[width] = c[width];
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      a_r <= '0;
      b_r <= '0;
      data_out <= '0;
    end else begin
      a_r <= a;
      b_r <= b;
      data_out <= sum;
    end
endmodule

// File: rtl/rca_share_arb.sv
// rca_share_arb: round-robin arbiter with burst limit sharing one registered adder
// between two requesters; results come back tagged with the requester id.
module rca_share_arb
  import rca_arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [N_REQ-1:0] in_valid,
  output logic [N_REQ-1:0] in_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             out_valid,
  output logic             out_id,
  output logic [WIDTH:0]   out_sum,
  output logic             idle
);
  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(BURST);
  logic last_owner, gnt, gnt_id, keep;
  logic [CW-1:0] burst_cnt;
  logic [WIDTH-1:0] add_a, add_b;
  tag_t s1, s2;
  // burst_cnt==0 means no history yet, so the first tie goes to ~last_owner (requester 0)
  always_comb begin
    keep = (burst_cnt != '0) && (burst_cnt < BMAX);
    gnt = en & |in_valid;
    gnt_id = &in_valid ? (keep ? last_owner : ~last_owner) : in_valid[1];
    in_ready = gnt ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    add_a = gnt ? (gnt_id ? a1 : a0) : '0;
    add_b = gnt ? (gnt_id ? b1 : b0) : '0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      last_owner <= 1'b1;
      burst_cnt <= '0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      if (gnt) begin
        last_owner <= gnt_id;
        burst_cnt <= (gnt_id != last_owner) ? CW'(1) : (burst_cnt == BMAX ? burst_cnt : burst_cnt + 1'b1);
      end
      s1 <= '{valid: gnt, id: gnt_id};
      s2 <= s1;
    end
  rca_w_regs #(.width(WIDTH)) u_add (
    .clk(clk),
    .rstn(rstn),
    .a(add_a),
    .b(add_b),
    .data_out(out_sum)
  );
  assign out_valid = s2.valid;
  assign out_id = s2.id;
  assign idle = ~s1.valid & ~s2.valid;
endmodule

// File: tb/tb_rca_share_arb.sv
// tb_rca_share_arb: scoreboard bench for the shared-adder arbiter (WIDTH=4, BURST=2)
module tb_rca_share_arb;
  import rca_arb_pkg::*;
  localparam int BURST = 2;
  typedef struct {
    logic       id;
    logic [4:0] sum;
    int         due;
  } exp_t;
  logic clk = 0, rstn = 0, en = 0;
  logic [1:0] in_valid = 0, in_ready;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic out_valid, out_id, idle;
  logic [4:0] out_sum;
  int n_checks = 0, n_fail = 0, cyc = 0;
  exp_t q[$];
  logic m_last = 1'b1;
  int m_cnt = 0;

  rca_share_arb #(.WIDTH(4), .BURST(BURST)) dut (
    .clk(clk), .rstn(rstn), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .out_valid(out_valid), .out_id(out_id), .out_sum(out_sum), .idle(idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rstn) begin
      if (out_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL result: unexpected out_valid id=%0d sum=%0d at cycle %0d", out_id, out_sum, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out_id !== e.id || out_sum !== e.sum || cyc != e.due) begin
            n_fail++;
            $display("FAIL result: got id=%0d sum=%0d cycle=%0d, expected id=%0d sum=%0d cycle=%0d",
                     out_id, out_sum, cyc, e.id, e.sum, e.due);
          end
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL result: missing id=%0d sum=%0d due cycle %0d", q[0].id, q[0].sum, q[0].due);
        void'(q.pop_front());
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Drive one cycle of inputs just after an edge, check grant and idle, and
  // record the expected result if the model says an acceptance will occur.
  task automatic drive(input logic e, input logic [1:0] v, input logic [3:0] x0, y0, x1, y1);
    logic [1:0] g;
    logic gid;
    exp_t t;
    @(posedge clk);
    #1;
    en = e; in_valid = v; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    #2;
    gid = (v == 2'b11) ? ((m_cnt != 0 && m_cnt < BURST) ? m_last : ~m_last) : v[1];
    g = (e && v != 2'b00) ? (gid ? 2'b10 : 2'b01) : 2'b00;
    n_checks++;
    if (in_ready !== g) begin
      n_fail++;
      $display("FAIL grant: in_ready=%b expected %b at cycle %0d", in_ready, g, cyc);
    end
    n_checks++;
    if (idle !== (q.size() == 0)) begin
      n_fail++;
      $display("FAIL idle: idle=%b expected %b at cycle %0d", idle, q.size() == 0, cyc);
    end
    if (g != 2'b00) begin
      t.id = gid;
      t.sum = gid ? ({1'b0, x1} + {1'b0, y1}) : ({1'b0, x0} + {1'b0, y0});
      t.due = cyc + PIPE_LAT;
      q.push_back(t);
      m_cnt = (gid != m_last) ? 1 : (m_cnt >= BURST ? BURST : m_cnt + 1);
      m_last = gid;
    end
  endtask

  task automatic hard_reset();
    #1;
    rstn = 0; in_valid = 0;
    q.delete();
    m_last = 1'b1;
    m_cnt = 0;
    @(posedge clk);
    #2;
    rstn = 1;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (out_valid !== 0 || idle !== 1 || out_sum !== 0 || out_id !== 0 || in_ready !== 0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b idle=%b sum=%0d id=%b rdy=%b, expected 0 1 0 0 00",
               out_valid, idle, out_sum, out_id, in_ready);
    end
    @(posedge clk);
    #2;
    rstn = 1;
    drive(1, 2'b11, 1, 2, 3, 4);
    drive(1, 2'b11, 5, 6, 7, 8);
    drive(1, 2'b11, 9, 1, 2, 3);
    #1;
    rstn = 0;
    in_valid = 0;
    #1;
    n_checks++;
    if (out_valid !== 0 || idle !== 1 || out_sum !== 0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b idle=%b sum=%0d, expected 0 1 0", out_valid, idle, out_sum);
    end
    q.delete();
    m_last = 1'b1;
    m_cnt = 0;
    @(posedge clk);
    #2;
    rstn = 1;
    repeat (4) drive(1, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_single();
    drive(1, 2'b01, 3, 5, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1 || out_id !== 0 || out_sum !== 5'd8) begin
      n_fail++;
      $display("FAIL single: valid=%b id=%b sum=%0d, expected 1 0 8", out_valid, out_id, out_sum);
    end
    drive(1, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 0) begin
      n_fail++;
      $display("FAIL single_after: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    drive(1, 2'b10, 0, 0, 15, 15);
    drive(1, 2'b10, 0, 0, 15, 1);
    drive(1, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1 || out_id !== 1 || out_sum !== 5'd30) begin
      n_fail++;
      $display("FAIL overflow_30: valid=%b id=%b sum=%0d, expected 1 1 30", out_valid, out_id, out_sum);
    end
    drive(1, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1 || out_id !== 1 || out_sum !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow_16: valid=%b id=%b sum=%0d, expected 1 1 16", out_valid, out_id, out_sum);
    end
    repeat (2) drive(1, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_contention();
    logic [1:0] ord[6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    hard_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 2'b11, 4'(i), 4'(i + 3), 4'(15 - i), 4'(2 * i));
      n_checks++;
      if (in_ready !== ord[i]) begin
        n_fail++;
        $display("FAIL contention_order[%0d]: in_ready=%b expected %b", i, in_ready, ord[i]);
      end
    end
    repeat (3) drive(1, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_burst_release();
    logic found;
    found = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b01, 4'(i + 1), 4'(9), 0, 0);
      n_checks++;
      if (in_ready !== 2'b01) begin
        n_fail++;
        $display("FAIL burst_solo[%0d]: in_ready=%b expected 01", i, in_ready);
      end
    end
    for (int i = 0; i < BURST; i++) begin
      drive(1, 2'b11, 4'(i), 4'(7), 4'(11), 4'(i + 2));
      if (in_ready === 2'b10) found = 1;
    end
    n_checks++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_release: req1 granted=%b expected 1 within %0d cycles", found, BURST);
    end
    repeat (3) drive(1, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic test_en_drain();
    drive(1, 2'b01, 7, 8, 0, 0);
    drive(1, 2'b10, 0, 0, 9, 6);
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b11, 1, 1, 2, 2);
      n_checks++;
      if (in_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL en_off[%0d]: in_ready=%b expected 00", i, in_ready);
      end
    end
    n_checks++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL en_drain_idle: idle=%b expected 1", idle);
    end
    drive(1, 2'b11, 4, 4, 12, 3);
    n_checks++;
    if (in_ready === 2'b00) begin
      n_fail++;
      $display("FAIL en_resume: in_ready=%b expected a grant", in_ready);
    end
    repeat (4) drive(1, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_burst_release();
    test_en_drain();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
